// File: rtl/c17_fault_sequencer.sv
// Fault-simulation sequencer for an external ISCAS c17: records golden responses, then replays all 32 patterns per fault.
// Optional macro C17_FSIM_DROP_EN: after a fault's first detection, skip the rest of its patterns.
module c17_fault_sequencer #(
   parameter int unsigned SETTLE_CYC = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic [4:0] pat,
   output logic [5:0] opcode,
   input  logic       n22,
   input  logic       n23,
   output logic       det_valid,
   input  logic       det_ready,
   output logic [5:0] det_opcode,
   output logic [4:0] det_pat,
   output logic       det_n22,
   output logic       det_n23,
   output logic       busy,
   output logic       done,
   output logic [4:0] undetected_cnt
);

`ifdef C17_FSIM_DROP_EN
   localparam bit DROP_EN = 1'b1;
`else
   localparam bit DROP_EN = 1'b0;
`endif

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
   localparam logic [4:0] LAST_FAULT  = 5'd21;
   localparam logic [4:0] NUM_FAULTS  = 5'd22;

   typedef enum logic [2:0] {IDLE, GOLD, FAULT, EMIT, FIN} state_t;

   function automatic logic [5:0] fault_opcode(input logic [4:0] idx);
      case (idx)
         5'd0:    return 6'h03;
         5'd1:    return 6'h11;
         5'd2:    return 6'h13;
         5'd3:    return 6'h07;
         5'd4:    return 6'h06;
         5'd5:    return 6'h0D;
         5'd6:    return 6'h05;
         5'd7:    return 6'h0F;
         5'd8:    return 6'h15;
         5'd9:    return 6'h29;
         5'd10:   return 6'h21;
         5'd11:   return 6'h20;
         5'd12:   return 6'h27;
         5'd13:   return 6'h2B;
         5'd14:   return 6'h2D;
         5'd15:   return 6'h2C;
         5'd16:   return 6'h2F;
         5'd17:   return 6'h2E;
         5'd18:   return 6'h17;
         5'd19:   return 6'h16;
         5'd20:   return 6'h1D;
         5'd21:   return 6'h1F;
         default: return 6'h00;
      endcase
   endfunction

   state_t          state_q;
   logic [4:0]      pat_q;
   logic [5:0]      opcode_q;
   logic [4:0]      f_q;
   logic [3:0]      cnt_q;
   logic            det_seen_q;
   logic [31:0][1:0] golden_q;
   logic            det_valid_q;
   logic [5:0]      det_opcode_q;
   logic [4:0]      det_pat_q;
   logic            det_n22_q;
   logic            det_n23_q;
   logic            busy_q;
   logic            done_q;
   logic [4:0]      undet_q;

   logic [1:0]      sample;
   logic            settle_last;
   logic            pat_wrap;
   state_t          adv_state_d;
   logic [4:0]      adv_pat_d;
   logic [4:0]      adv_f_d;
   logic [5:0]      adv_opcode_d;
   logic            adv_new_fault;

   assign sample      = {n22, n23};
   assign settle_last = (cnt_q == SETTLE_LAST);
   // In drop mode a handshake in EMIT ends the fault just like finishing pattern 31.
   assign pat_wrap    = (pat_q == 5'd31) || (DROP_EN && (state_q == EMIT));

   // Where the campaign goes once the current pattern of the current fault is finished.
   always_comb begin
      adv_state_d   = FAULT;
      adv_pat_d     = pat_q + 5'd1;
      adv_f_d       = f_q;
      adv_opcode_d  = opcode_q;
      adv_new_fault = 1'b0;
      if (pat_wrap) begin
         adv_pat_d = 5'd0;
         if (f_q == LAST_FAULT) begin
            adv_state_d  = FIN;
            adv_f_d      = 5'd0;
            adv_opcode_d = 6'h00;
         end else begin
            adv_f_d       = f_q + 5'd1;
            adv_opcode_d  = fault_opcode(f_q + 5'd1);
            adv_new_fault = 1'b1;
         end
      end
   end

   // NOTE: state is updated with non-blocking assignments so every branch reads pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         pat_q        <= '0;
         opcode_q     <= '0;
         f_q          <= '0;
         cnt_q        <= '0;
         det_seen_q   <= 1'b0;
         // NOTE: the golden table is cleared on reset so a campaign never compares against stale data.
         golden_q     <= '0;
         det_valid_q  <= 1'b0;
         det_opcode_q <= '0;
         det_pat_q    <= '0;
         det_n22_q    <= 1'b0;
         det_n23_q    <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         undet_q      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  state_q    <= GOLD;
                  pat_q      <= '0;
                  opcode_q   <= '0;
                  f_q        <= '0;
                  cnt_q      <= '0;
                  det_seen_q <= 1'b0;
                  busy_q     <= 1'b1;
                  undet_q    <= '0;
               end
            end
            GOLD: begin
               if (settle_last) begin
                  cnt_q             <= '0;
                  golden_q[pat_q]   <= sample;
                  if (pat_q == 5'd31) begin
                     state_q    <= FAULT;
                     pat_q      <= '0;
                     f_q        <= '0;
                     opcode_q   <= fault_opcode(5'd0);
                     det_seen_q <= 1'b0;
                  end else begin
                     pat_q <= pat_q + 5'd1;
                  end
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            FAULT: begin
               if (settle_last) begin
                  cnt_q <= '0;
                  if (sample != golden_q[pat_q]) begin
                     state_q      <= EMIT;
                     det_valid_q  <= 1'b1;
                     det_opcode_q <= opcode_q;
                     det_pat_q    <= pat_q;
                     det_n22_q    <= n22;
                     det_n23_q    <= n23;
                     det_seen_q   <= 1'b1;
                  end else begin
                     if (pat_wrap && !det_seen_q && (undet_q != NUM_FAULTS))
                        undet_q <= undet_q + 5'd1;
                     state_q  <= adv_state_d;
                     pat_q    <= adv_pat_d;
                     f_q      <= adv_f_d;
                     opcode_q <= adv_opcode_d;
                     if (adv_new_fault) det_seen_q <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            EMIT: begin
               // Pattern and opcode stay frozen until the record is accepted.
               if (det_ready) begin
                  det_valid_q <= 1'b0;
                  state_q     <= adv_state_d;
                  pat_q       <= adv_pat_d;
                  f_q         <= adv_f_d;
                  opcode_q    <= adv_opcode_d;
                  if (adv_new_fault) det_seen_q <= 1'b0;
               end
            end
            FIN: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign pat            = pat_q;
   assign opcode         = opcode_q;
   assign det_valid      = det_valid_q;
   assign det_opcode     = det_opcode_q;
   assign det_pat        = det_pat_q;
   assign det_n22        = det_n22_q;
   assign det_n23        = det_n23_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign undetected_cnt = undet_q;

endmodule

// File: doc/c17_fault_sequencer.md
C17_FAULT_SEQUENCER -- requirements
Module: c17_fault_sequencer

Interface
REQ-001 Parameter: SETTLE_CYC, default 1, cycles each pattern is held before sampling (range 1-15).
REQ-002 Port clk, in, 1: sole clock; all state updates on its rising edge.
REQ-003 Port rst, in, 1: reset, asynchronous, active-high.
REQ-004 Port start, in, 1: begin a campaign; sampled only in IDLE.
REQ-005 Port pat, out, 5: applied pattern; pat[0]=N1, pat[1]=N2, pat[2]=N3, pat[3]=N6, pat[4]=N7.
REQ-006 Port opcode, out, 6: fault-select code to the c17 under test; 0 = fault-free.
REQ-007 Ports n22 and n23, in, 1 each: c17 outputs (combinational from pat/opcode).
REQ-008 Ports det_valid (out, 1) and det_ready (in, 1): detection-record handshake.
REQ-009 Ports det_opcode (out, 6), det_pat (out, 5), det_n22 (out, 1), det_n23 (out, 1): detection record.
REQ-010 Ports busy (out, 1), done (out, 1), undetected_cnt (out, 5): status.

Function
REQ-011 The FSM SHALL use states IDLE, GOLD, FAULT, EMIT, FIN.
REQ-012 IDLE: start=1 SHALL go to GOLD with pat=0 and opcode=0; start in any other state SHALL be ignored.
REQ-013 GOLD: each pattern SHALL be held SETTLE_CYC cycles; on the last cycle, {n22,n23} SHALL be written to golden[pat].
REQ-014 GOLD: pat SHALL then increment; after pat=31, the FSM SHALL enter FAULT with fault index f=0 and pat=0.
REQ-015 FAULT: opcode SHALL equal table[f], the fixed 22-entry hex table 03,11,13,07,06,0D,05,0F,15,29,21,20,27,2B,2D,2C,2F,2E,17,16,1D,1F.
REQ-016 FAULT: each pattern SHALL be held SETTLE_CYC cycles; on the last cycle, {n22,n23} SHALL be compared with golden[pat].
REQ-017 On a mismatch in FAULT, the FSM SHALL go to EMIT; on a match, it SHALL advance the pattern.
REQ-018 EMIT: det_valid=1, det_opcode=table[f], det_pat=pat, and det_n22/det_n23=sampled values SHALL be held stable until det_ready=1.
REQ-019 EMIT: pat and opcode SHALL stay frozen; on handshake, det_valid SHALL drop the next cycle and the pattern SHALL advance.
REQ-020 Pattern advance after pat=31 SHALL move to f+1, pat=0.
REQ-021 A fault with zero mismatches over its patterns SHALL increment undetected_cnt (saturating at 22).
REQ-022 After f=21, the FSM SHALL enter FIN, pulse done for exactly one cycle, then return to IDLE.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 undetected_cnt SHALL hold its value until the next start, which clears it.
REQ-025 Timing (SETTLE_CYC=1, no detections): done SHALL be high exactly 737 cycles after the start-sampling edge.

Reset
REQ-026 rst=1, at any time including mid-campaign, SHALL force IDLE, pat=0, opcode=0, det_valid=0, det_* fields=0, busy=0, done=0, undetected_cnt=0, f=0, and all golden entries=0.
REQ-027 After reset deassertion, the block SHALL do nothing until start.

Configuration
REQ-028 Macro C17_FSIM_DROP_EN defined: after a fault's first detection handshake, remaining patterns of that fault SHALL be skipped (next f, pat=0).
REQ-029 Macro C17_FSIM_DROP_EN absent: all 32 patterns SHALL be applied per fault, and every mismatch SHALL be emitted.

Verification
REQ-030 Reset, then start with a correct c17 model -> busy=1 next cycle; GOLD steps pat 0..31 with opcode=0; golden[0]={0,0}, golden[31]={1,0}.
REQ-031 Model ignores opcode, det_ready=1 -> no det_valid, undetected_cnt=22, done 737 cycles after start.
REQ-032 Model forces n22=1 only when opcode=0x03, macro absent -> one record per pattern with golden n22=0, each with det_opcode=0x03 and det_n22=1; undetected_cnt=21.
REQ-033 Same as REQ-032 with det_ready=0 for 10 cycles on the first record -> det_valid and all det_* fields stable for 10 cycles, with pat and opcode frozen.
REQ-034 Same as REQ-032 with C17_FSIM_DROP_EN -> exactly one record (det_opcode=0x03, det_pat=0x00); undetected_cnt=21.
REQ-035 rst pulse during FAULT at f=5 -> all outputs at reset values the same cycle; a new start re-runs GOLD from pat=0.
